video_ula_gen: RTL and testbench

//  Parametrised video serialiser/palette ULA for the BBC display path: loads one screen

---
 rtl/video_ula_gen.sv | 118 +++++++++++
 tb/tb_video_ula_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/video_ula_gen.sv
// Video serialiser/palette ULA: per-character screen byte load, pixel shift, 16-entry palette, cursor/flash inversion, blanking.
// Latency: a byte loaded on crtc_ce at edge E shows its first pixel on red/green/blue after E+1, then one pixel per pixel period.
// No backpressure: bytes are sampled on crtc_ce only, never buffered; a byte missed during reset is lost. Flash is built in when VULA_FLASH_EN is defined.
module video_ula_gen #(
  parameter  int CHAN_W = 1,
  localparam int PAL_W  = 1 + 3*CHAN_W
) (
  input  logic               clk16MHz,
  input  logic               RESET,
  input  logic               reg_we,
  input  logic               reg_a0,
  input  logic [PAL_W+3:0]   reg_wdata,
  input  logic               DISEN,
  input  logic               CURSOR,
  input  logic [7:0]         DATA,
  output logic               crtc_ce,
  output logic               pix_ce,
  output logic [CHAN_W-1:0]  red,
  output logic [CHAN_W-1:0]  green,
  output logic [CHAN_W-1:0]  blue
);

  logic [3:0]          cnt;
  logic [7:0]          ctrl;
  logic [7:0]          sr;
  logic [PAL_W-1:0]    pal [16];
  logic [3:0]          cseg;
  logic                cur_q;
  logic [3*CHAN_W-1:0] rgb_q;

  logic [3:0]          idx;
  logic [PAL_W-1:0]    pal_ent;
  logic [3*CHAN_W-1:0] col;
  logic [3*CHAN_W-1:0] rgb_d;
  logic                cur_w;
  logic                cur;
  logic                flash_act;
  logic                inv;
  logic                unused_bits;

  // Character-rate enable: fast mode every 8 clocks, slow mode every 16; decode follows ctrl[4] at once.
  assign crtc_ce = ctrl[4] ? (cnt[2:0] == 3'd7) : (cnt == 4'd15);

  // Pixel-rate enable selected by ctrl[3:2] (2/4/8/16 MHz).
  always_comb begin
    pix_ce = 1'b0;
    case (ctrl[3:2])
      2'b00:   pix_ce = (cnt[2:0] == 3'd7);
      2'b01:   pix_ce = (cnt[1:0] == 2'd3);
      2'b10:   pix_ce = cnt[0];
      default: pix_ce = 1'b1;
    endcase
  end

  // Free-running divider shared by both enables.
  always_ff @(posedge clk16MHz) begin
    if (RESET) cnt <= 4'd0;
    else       cnt <= cnt + 4'd1;
  end

  // Register file: control byte and palette; reset takes priority over a coincident write.
  always_ff @(posedge clk16MHz) begin
    if (RESET) begin
      ctrl <= 8'h00;
      for (int i = 0; i < 16; i++) pal[i] <= '0;
    end else if (reg_we) begin
      if (reg_a0) pal[reg_wdata[PAL_W+3:PAL_W]] <= reg_wdata[PAL_W-1:0];
      else        ctrl <= reg_wdata[7:0];
    end
  end

  // Shift register: a new byte on each character slot wins over a pixel shift; ones fill from the bottom.
  always_ff @(posedge clk16MHz) begin
    if (RESET)        sr <= 8'h00;
    else if (crtc_ce) sr <= DATA;
    else if (pix_ce)  sr <= {sr[6:0], 1'b1};
  end

  // Cursor segment tracker: one-hot walk across four character slots; fast mode uses a one-slot-delayed copy.
  always_ff @(posedge clk16MHz) begin
    if (RESET) begin
      cseg  <= 4'd0;
      cur_q <= 1'b0;
    end else if (crtc_ce) begin
      cseg  <= CURSOR ? 4'b0001 : {cseg[2:0], 1'b0};
      cur_q <= cur_w;
    end
  end

  // Palette lookup, inversion and blanking for the pixel at the top of the shift register.
  always_comb begin
    idx     = {sr[7], sr[5], sr[3], sr[1]};
    pal_ent = pal[idx];
    col     = pal_ent[3*CHAN_W-1:0];
    cur_w   = (cseg[0] & ctrl[7]) | (cseg[1] & ctrl[6]) | ((cseg[2] | cseg[3]) & ctrl[5]);
    cur     = ctrl[4] ? cur_q : cur_w;
`ifdef VULA_FLASH_EN
    flash_act   = pal_ent[PAL_W-1] & ctrl[0];
    unused_bits = ctrl[1];
`else
    flash_act   = 1'b0;
    unused_bits = ^{ctrl[1:0], pal_ent[PAL_W-1]};
`endif
    inv   = cur ^ flash_act;
    rgb_d = DISEN ? (inv ? ~col : col) : '0;
  end

  // Output register; DISEN and ctrl act at this edge, not aligned with the shift register.
  always_ff @(posedge clk16MHz) begin
    if (RESET) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign red   = rgb_q[CHAN_W-1:0];
  assign green = rgb_q[2*CHAN_W-1:CHAN_W];
  assign blue  = rgb_q[3*CHAN_W-1:2*CHAN_W];

endmodule

// File: tb/tb_video_ula_gen.sv
// Directed bench for video_ula_gen: CHAN_W=1 instance plus a CHAN_W=4 instance sharing the stimulus.
// Inputs are driven and outputs sampled on the falling edge of clk16MHz.
// Expected colours are hand-derived from the palette contents and the loaded screen bytes.
module tb_video_ula_gen;

  logic        clk16MHz = 1'b0;
  logic        RESET    = 1'b1;
  logic        reg_we   = 1'b0;
  logic        reg_a0   = 1'b0;
  logic [7:0]  wd1      = 8'h00;
  logic [16:0] wd4      = 17'h0;
  logic        DISEN    = 1'b0;
  logic        CURSOR   = 1'b0;
  logic [7:0]  DATA     = 8'h00;

  logic        crtc_ce, pix_ce, red1, green1, blue1;
  logic        crtc_ce4, pix_ce4;
  logic [3:0]  red4, green4, blue4;
  logic [2:0]  rgb1;
  logic [11:0] rgb4;

  int n_tests = 0;
  int n_fail  = 0;

  assign rgb1 = {blue1, green1, red1};
  assign rgb4 = {blue4, green4, red4};

  video_ula_gen #(.CHAN_W(1)) dut1 (
    .clk16MHz(clk16MHz), .RESET(RESET), .reg_we(reg_we), .reg_a0(reg_a0), .reg_wdata(wd1),
    .DISEN(DISEN), .CURSOR(CURSOR), .DATA(DATA), .crtc_ce(crtc_ce), .pix_ce(pix_ce),
    .red(red1), .green(green1), .blue(blue1));

  video_ula_gen #(.CHAN_W(4)) dut4 (
    .clk16MHz(clk16MHz), .RESET(RESET), .reg_we(reg_we), .reg_a0(reg_a0), .reg_wdata(wd4),
    .DISEN(DISEN), .CURSOR(CURSOR), .DATA(DATA), .crtc_ce(crtc_ce4), .pix_ce(pix_ce4),
    .red(red4), .green(green4), .blue(blue4));

  always #31 clk16MHz = ~clk16MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] x4(input logic [3:0] e);
    return {e[3], {4{e[2]}}, {4{e[1]}}, {4{e[0]}}};
  endfunction

  task automatic wr_ctrl(input logic [7:0] c);
    reg_we = 1'b1; reg_a0 = 1'b0; wd1 = c; wd4 = {9'h0, c};
    @(negedge clk16MHz);
    reg_we = 1'b0;
  endtask

  task automatic wr_pal(input logic [3:0] i, input logic [3:0] e1, input logic [12:0] e4);
    reg_we = 1'b1; reg_a0 = 1'b1; wd1 = {i, e1}; wd4 = {i, e4};
    @(negedge clk16MHz);
    reg_we = 1'b0;
  endtask

  // Returns on the falling edge just before a loading edge.
  task automatic wait_crtc();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk16MHz);
      if (crtc_ce) begin
        seen = 1'b1;
        break;
      end
    end
    chk("crtc_wait", 32'(seen), 32'h1);
  endtask

  initial begin
    #(62 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_hi, second_hi, n_pix;
    logic [31:0] exp;

    // Reset and divider phase
    repeat (2) @(posedge clk16MHz);
    @(negedge clk16MHz);
    chk("rst_rgb1", 32'(rgb1), 32'h0);
    chk("rst_rgb4", 32'(rgb4), 32'h0);
    chk("rst_crtc", 32'(crtc_ce), 32'h0);
    RESET = 1'b0;
    first_hi = -1; second_hi = -1; n_pix = 0;
    for (int k = 0; k < 32; k++) begin
      if (crtc_ce) begin
        if (first_hi < 0) first_hi = k;
        else if (second_hi < 0) second_hi = k;
      end
      if (pix_ce) n_pix++;
      @(negedge clk16MHz);
    end
    chk("crtc_first", 32'(first_hi), 32'd15);
    chk("crtc_second", 32'(second_hi), 32'd31);
    chk("pix_cnt_2mhz", 32'(n_pix), 32'd4);

    // Fast mode, 16 MHz pixels, alternating palette entries
    DISEN = 1'b1; DATA = 8'hAA;
    wr_ctrl(8'h1C);
    wr_pal(4'hF, 4'h7, 13'h0A5C);
    wr_pal(4'h0, 4'h1, 13'h0123);
    wait_crtc();
    @(negedge clk16MHz);
    @(negedge clk16MHz);
    chk("px0_c1", 32'(rgb1), 32'h7);  chk("px0_c4", 32'(rgb4), 32'hA5C);
    @(negedge clk16MHz);
    chk("px1_c1", 32'(rgb1), 32'h1);  chk("px1_c4", 32'(rgb4), 32'h123);
    @(negedge clk16MHz);
    chk("px2_c1", 32'(rgb1), 32'h7);  chk("px2_c4", 32'(rgb4), 32'hA5C);

    // Flash bit enable
    DATA = 8'hFF;
    wr_pal(4'hF, 4'hC, x4(4'hC));
    wait_crtc();
    repeat (2) @(negedge clk16MHz);
    chk("flash_off", 32'(rgb1), 32'h4);
    wr_ctrl(8'h1D);
    @(negedge clk16MHz);
`ifdef VULA_FLASH_EN
    exp = 32'h3;
`else
    exp = 32'h4;
`endif
    chk("flash_on", 32'(rgb1), exp);

    // Cursor, slow mode: four 16-clock slots inverted starting right after the pulse slot
    wr_pal(4'hF, 4'h1, x4(4'h1));
    wr_ctrl(8'hE0);
    wait_crtc();
    CURSOR = 1'b1;
    @(negedge clk16MHz);
    CURSOR = 1'b0;
    for (int k = 0; k <= 80; k++) begin
      chk($sformatf("cur_slow_k%0d", k), 32'(rgb1), (k >= 1 && k <= 64) ? 32'h6 : 32'h1);
      @(negedge clk16MHz);
    end

    // Cursor, fast mode: four 8-clock slots, one slot late
    wr_ctrl(8'hF0);
    wait_crtc();
    CURSOR = 1'b1;
    @(negedge clk16MHz);
    CURSOR = 1'b0;
    for (int k = 0; k <= 56; k++) begin
      chk($sformatf("cur_fast_k%0d", k), 32'(rgb1), (k >= 9 && k <= 40) ? 32'h6 : 32'h1);
      @(negedge clk16MHz);
    end

    // Blanking wins over palette and cursor
    DISEN = 1'b0; CURSOR = 1'b1;
    wr_ctrl(8'hE0);
    for (int k = 0; k < 20; k++) begin
      if (k % 4 == 0) chk($sformatf("blank_k%0d", k), 32'(rgb1), 32'h0);
      @(negedge clk16MHz);
    end
    chk("blank_c4", 32'(rgb4), 32'h0);
    CURSOR = 1'b0; DISEN = 1'b1;
    repeat (40) @(negedge clk16MHz);

    // Palette write coincident with reset is discarded
    RESET = 1'b1;
    reg_we = 1'b1; reg_a0 = 1'b1; wd1 = {4'h5, 4'h7}; wd4 = {4'h5, x4(4'h7)};
    @(negedge clk16MHz);
    reg_we = 1'b0;
    chk("midrst_rgb", 32'(rgb1), 32'h0);
    RESET = 1'b0;
    DATA = 8'h22;
    wr_ctrl(8'h1C);
    wait_crtc();
    repeat (2) @(negedge clk16MHz);
    chk("pal_rst_wins", 32'(rgb1), 32'h0);

    // Palette write on the loading edge is used by the very next pixel
    wait_crtc();
    wr_pal(4'h5, 4'h2, x4(4'h2));
    @(negedge clk16MHz);
    chk("pal_wr_ce_c1", 32'(rgb1), 32'h2);
    chk("pal_wr_ce_c4", 32'(rgb4), 32'h0F0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
